// File: rtl/fp16_argmax_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp16_argmax_tracker_pkg
// Description : Shared fp16 field bounds, score type and tracker FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package fp16_argmax_tracker_pkg;

    typedef logic [15:0] fp16_t;

    localparam int FP16_SIGN    = 15;
    localparam int FP16_EXP_HI  = 14;
    localparam int FP16_EXP_LO  = 10;
    localparam int FP16_MANT_HI = 9;
    localparam int FP16_MANT_LO = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } argmax_state_t;

endpackage : fp16_argmax_tracker_pkg
`default_nettype wire

// File: rtl/fp16_argmax_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : fp16_argmax_tracker_if
// Description : Score stream in, winner result out, plus frame-busy status.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp16_argmax_tracker_if #(
    parameter int IDX_W = 5
);
    import fp16_argmax_tracker_pkg::*;

    logic             score_valid;
    logic             score_ready;
    fp16_t            score_data;
    logic             score_last;
    logic             result_valid;
    logic             result_ready;
    logic [IDX_W-1:0] result_class;
    fp16_t            result_score;
    logic             result_err;
    logic             busy;

    // Producer of scores / consumer of the winner
    modport master (
        output score_valid, score_data, score_last, result_ready,
        input  score_ready, result_valid, result_class, result_score,
               result_err, busy
    );

    // The tracker itself
    modport slave (
        input  score_valid, score_data, score_last, result_ready,
        output score_ready, result_valid, result_class, result_score,
               result_err, busy
    );

endinterface : fp16_argmax_tracker_if
`default_nettype wire

// File: rtl/fp16_argmax_tracker_greater.sv
`default_nettype none
// ============================================================================
// Module      : fp16_greater
// Description : Combinational strict "a > b" on fp16 bit patterns. Sign first
//               (+0 beats -0), then magnitude, inverted for negatives. No
//               NaN/Inf special handling; equal patterns are not greater.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_greater
    import fp16_argmax_tracker_pkg::*;
(
    input  fp16_t a,
    input  fp16_t b,
    output logic  gt
);

    logic        w_a_neg;
    logic        w_b_neg;
    logic [14:0] w_a_mag;
    logic [14:0] w_b_mag;

    assign w_a_neg = a[FP16_SIGN];
    assign w_b_neg = b[FP16_SIGN];
    assign w_a_mag = {a[FP16_EXP_HI:FP16_EXP_LO], a[FP16_MANT_HI:FP16_MANT_LO]};
    assign w_b_mag = {b[FP16_EXP_HI:FP16_EXP_LO], b[FP16_MANT_HI:FP16_MANT_LO]};

    // Sign decides when they differ; otherwise magnitude, reversed for negatives
    always_comb begin
        gt = 1'b0;
        if (w_a_neg != w_b_neg) begin
            gt = ~w_a_neg;
        end else if (!w_a_neg) begin
            gt = (w_a_mag > w_b_mag);
        end else begin
            gt = (w_a_mag < w_b_mag);
        end
    end

endmodule : fp16_greater
`default_nettype wire

// File: rtl/fp16_argmax_tracker.sv
`default_nettype none
// ============================================================================
// Module      : fp16_argmax_tracker
// Description : Streaming arg-max over NUM_CLASSES fp16 scores per frame.
//               One comparison per accepted beat; winner index/score held
//               in registers until the downstream handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_argmax_tracker
    import fp16_argmax_tracker_pkg::*;
#(
    parameter int NUM_CLASSES = 26,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    fp16_argmax_tracker_if.slave bus
);

    // Counter must be able to hold NUM_CLASSES itself, where it saturates
    localparam int               CNT_W     = $clog2(NUM_CLASSES + 1);
    localparam logic [CNT_W-1:0] c_num_cls = CNT_W'(NUM_CLASSES);

    argmax_state_t    r_state;
    logic             r_score_ready;
    logic             r_result_valid;
    logic [IDX_W-1:0] r_result_class;
    fp16_t            r_result_score;
    logic             r_result_err;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    fp16_t            r_best;
    logic [IDX_W-1:0] r_idx;

    logic             w_accept;
    logic             w_gt;
    fp16_t            w_best_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;
    logic             w_err_nxt;

    // score_ready is a register, so acceptance never depends combinationally on itself
    assign w_accept = bus.score_valid & r_score_ready;

    fp16_greater u_greater (
        .a  (bus.score_data),
        .b  (r_best),
        .gt (w_gt)
    );

    // Best/index/count after absorbing the current beat; beats past a full frame only flag overflow
    always_comb begin
        w_best_nxt = r_best;
        w_idx_nxt  = r_idx;
        w_cnt_nxt  = r_cnt;
        w_ovf_nxt  = r_ovf;
        if (r_state == IDLE) begin
            w_best_nxt = bus.score_data;
            w_idx_nxt  = '0;
            w_cnt_nxt  = CNT_W'(1);
            w_ovf_nxt  = 1'b0;
        end else if (r_cnt == c_num_cls) begin
            w_ovf_nxt  = 1'b1;
        end else begin
            w_cnt_nxt  = r_cnt + CNT_W'(1);
            if (w_gt) begin
                w_best_nxt = bus.score_data;
                w_idx_nxt  = r_cnt[IDX_W-1:0];
            end
        end
        w_err_nxt = (w_cnt_nxt != c_num_cls) | w_ovf_nxt;
    end

    // Frame FSM with registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_score_ready  <= 1'b1;
            r_result_valid <= 1'b0;
            r_result_class <= '0;
            r_result_score <= '0;
            r_result_err   <= 1'b0;
            r_busy         <= 1'b0;
            r_cnt          <= '0;
            r_ovf          <= 1'b0;
            r_best         <= '0;
            r_idx          <= '0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_best <= w_best_nxt;
                        r_idx  <= w_idx_nxt;
                        r_cnt  <= w_cnt_nxt;
                        r_ovf  <= w_ovf_nxt;
                        if (bus.score_last) begin
                            r_state        <= DONE;
                            r_score_ready  <= 1'b0;
                            r_result_valid <= 1'b1;
                            r_result_class <= w_idx_nxt;
                            r_result_score <= w_best_nxt;
                            r_result_err   <= w_err_nxt;
                            r_busy         <= 1'b0;
                        end else begin
                            r_state <= ACCUM;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        r_state        <= IDLE;
                        r_score_ready  <= 1'b1;
                        r_result_valid <= 1'b0;
                        r_cnt          <= '0;
                        r_ovf          <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_score_ready <= 1'b1;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.score_ready  = r_score_ready;
    assign bus.result_valid = r_result_valid;
    assign bus.result_class = r_result_class;
    assign bus.result_score = r_result_score;
    assign bus.result_err   = r_result_err;
    assign bus.busy         = r_busy;

endmodule : fp16_argmax_tracker
`default_nettype wire

// File: tb/tb_fp16_argmax_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_argmax_tracker
// Description : Directed table-driven bench for the fp16 arg-max tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_argmax_tracker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fp16_argmax_tracker_if #(.IDX_W(5)) bus ();

    fp16_argmax_tracker #(.NUM_CLASSES(26), .IDX_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          n;
        logic [15:0] base;
        bit          ramp;
        int          p0_i;
        logic [15:0] p0_v;
        int          p1_i;
        logic [15:0] p1_v;
        int          exp_cls;
        logic [15:0] exp_score;
        bit          exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] beat_val(input vec_t v, input int i);
        logic [15:0] s;
        s = v.ramp ? (v.base + 16'(i)) : v.base;
        if (i == v.p0_i) s = v.p0_v;
        if (i == v.p1_i) s = v.p1_v;
        return s;
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (!bus.score_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.score_ready) chk("score_ready_timeout", 32'(bus.score_ready), 32'd1);
    endtask

    task automatic send_frame(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            bus.score_valid = 1'b1;
            bus.score_data  = beat_val(v, i);
            bus.score_last  = (i == v.n - 1);
            wait_ready();
            @(posedge clk); #1;
        end
        bus.score_valid = 1'b0;
        bus.score_last  = 1'b0;
        bus.score_data  = 16'h0000;
    endtask

    task automatic check_result(input vec_t v);
        chk("result_valid", 32'(bus.result_valid), 32'd1);
        chk("result_class", 32'(bus.result_class), 32'(v.exp_cls));
        chk("result_score", 32'(bus.result_score), 32'(v.exp_score));
        chk("result_err",   32'(bus.result_err),   32'(v.exp_err));
    endtask

    task automatic handshake(input vec_t v);
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        chk("post_hs_valid", 32'(bus.result_valid), 32'd0);
        chk("post_hs_ready", 32'(bus.score_ready),  32'd1);
        chk("post_hs_score_kept", 32'(bus.result_score), 32'(v.exp_score));
    endtask

    initial begin
        //          n   base      ramp p0i p0v      p1i p1v      cls score    err
        vecs[0] = '{26, 16'h3800, 1'b1, 7, 16'h4A00, -1, 16'h0000, 7, 16'h4A00, 1'b0};
        vecs[1] = '{26, 16'hC000, 1'b1, -1, 16'h0000, -1, 16'h0000, 0, 16'hC000, 1'b0};
        vecs[2] = '{26, 16'h3000, 1'b0, 3, 16'h3C00, 12, 16'h3C00, 3, 16'h3C00, 1'b0};
        vecs[3] = '{26, 16'hBC00, 1'b0, 0, 16'h8000, 1, 16'h0000, 1, 16'h0000, 1'b0};
        vecs[4] = '{10, 16'h3400, 1'b1, 5, 16'h4000, -1, 16'h0000, 5, 16'h4000, 1'b1};
        vecs[5] = '{30, 16'h3000, 1'b0, 20, 16'h4400, 27, 16'h7BFF, 20, 16'h4400, 1'b1};
        vecs[6] = '{1,  16'h5555, 1'b0, -1, 16'h0000, -1, 16'h0000, 0, 16'h5555, 1'b1};
        vecs[7] = '{26, 16'hC500, 1'b0, 25, 16'h0001, -1, 16'h0000, 25, 16'h0001, 1'b0};
        vecs[8] = '{26, 16'h3C01, 1'b0, 24, 16'h3C02, -1, 16'h0000, 24, 16'h3C02, 1'b0};
        vecs[9] = '{26, 16'hB801, 1'b0, 9, 16'hB800, -1, 16'h0000, 9, 16'hB800, 1'b0};

        bus.score_valid  = 1'b0;
        bus.score_data   = 16'h0000;
        bus.score_last   = 1'b0;
        bus.result_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result_valid", 32'(bus.result_valid), 32'd0);
        chk("rst_result_class", 32'(bus.result_class), 32'd0);
        chk("rst_result_score", 32'(bus.result_score), 32'd0);
        chk("rst_result_err",   32'(bus.result_err),   32'd0);
        chk("rst_busy",         32'(bus.busy),         32'd0);
        chk("rst_score_ready",  32'(bus.score_ready),  32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 10; t++) begin
            send_frame(vecs[t]);
            check_result(vecs[t]);
            handshake(vecs[t]);
        end

        // Back-pressure: result held while result_ready low, new beats refused
        send_frame(vecs[0]);
        bus.score_valid = 1'b1;
        bus.score_data  = 16'h7BFF;
        bus.score_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("hold_valid",       32'(bus.result_valid), 32'd1);
            chk("hold_score_ready", 32'(bus.score_ready),  32'd0);
            chk("hold_class",       32'(bus.result_class), 32'd7);
            chk("hold_score",       32'(bus.result_score), 32'h4A00);
        end
        bus.score_valid = 1'b0;
        bus.score_last  = 1'b0;
        handshake(vecs[0]);

        // Mid-frame reset discards partial frame
        for (int i = 0; i < 5; i++) begin
            bus.score_valid = 1'b1;
            bus.score_data  = 16'h7000;
            bus.score_last  = 1'b0;
            @(posedge clk); #1;
        end
        bus.score_valid = 1'b0;
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mr_result_valid", 32'(bus.result_valid), 32'd0);
        chk("mr_busy",         32'(bus.busy),         32'd0);
        chk("mr_score_ready",  32'(bus.score_ready),  32'd1);
        send_frame(vecs[2]);
        check_result(vecs[2]);
        handshake(vecs[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_fp16_argmax_tracker
`default_nettype wire
